// File: rtl/shift_register_scheduler_pkg.sv
// Shared definitions for the shift register scheduler: operation and FSM
// encodings, width constants, and helpers that build one shift register
// command and resolve the effective operation length.
package shift_register_sched_pkg;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_RIGHT = 2'd1,
    OP_LEFT  = 2'd2,
    OP_LOAD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             rst;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] data;
  } sr_cmd_t;

  // Command for RUN cycle idx of an operation. Right shifts feed the MSB
  // from payload LSB first; left shifts feed the LSB from payload MSB first,
  // so a full-length shift of either direction leaves q equal to payload.
  function automatic sr_cmd_t sr_cmd(op_e op, logic [WIDTH-1:0] payload, logic [2:0] idx);
    sr_cmd_t c;
    c = '0;
    case (op)
      OP_CLEAR: c.rst = 1'b1;
      OP_RIGHT: begin
        c.ctrl    = 2'd1;
        c.data[7] = payload[idx];
      end
      OP_LEFT: begin
        c.ctrl    = 2'd2;
        c.data[0] = payload[3'd7 - idx];
      end
      OP_LOAD: begin
        c.ctrl = 2'd3;
        c.data = payload;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Clear and load take one cycle; shift lengths of 0 or above 8 mean 8.
  function automatic logic [LEN_W-1:0] eff_len(op_e op, logic [LEN_W-1:0] len);
    if (op == OP_CLEAR || op == OP_LOAD) begin
      return 4'd1;
    end else if (len == 4'd0 || len > 4'd8) begin
      return 4'd8;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/shift_register_scheduler_if.sv
// Request bus of the shift register scheduler: two requesters sharing one
// valid/ready handshake bundle. Index 0 is requester A, index 1 is B.
//   req_valid   [1:0]  per-requester request valid
//   req_ready   [1:0]  per-requester accept (at most one bit high)
//   req_op      [3:0]  2 bits per requester
//   req_payload [15:0] 8 bits per requester
//   req_len     [7:0]  4 bits per requester
interface shift_register_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_payload;
  logic [7:0]  req_len;

  modport master (output req_valid, output req_op, output req_payload,
                  output req_len, input req_ready);
  modport slave  (input req_valid, input req_op, input req_payload,
                  input req_len, output req_ready);
endinterface

// File: rtl/shift_register_scheduler_arb.sv
// Two-way round-robin grant: a lone request is granted directly; when both
// request, the pointer side wins.
//   i_req   [1:0] request vector
//   i_ptr         preferred requester on a tie (0 = A, 1 = B)
//   o_grant [1:0] one-hot grant, zero when nothing requests
module rr_arbiter_2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  logic [1:0] w_grant;

  // Tie-break by pointer, otherwise pass the single request through.
  always_comb begin
    w_grant = 2'b00;
    if (i_req == 2'b11) begin
      w_grant = i_ptr ? 2'b10 : 2'b01;
    end else begin
      w_grant = i_req;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/shift_register_scheduler.sv
// Schedules shift register operations from two requesters. An accepted
// request runs for its effective length in RUN, then DONE pulses done for
// the owner for one cycle before returning to IDLE.
//   clk, resetn        clock, asynchronous active-low reset
//   req                request bus (slave side)
//   abort              ends the running operation after the current cycle
//   sr_reset/ctrl/data registered shift register command
//   busy               high in RUN and DONE
//   done, done_aborted completion pulse and abort qualifier
module shift_register_scheduler
  import shift_register_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  shift_register_scheduler_if.slave  req,
  input  logic                       abort,
  output logic                       sr_reset,
  output logic [1:0]                 sr_ctrl,
  output logic [WIDTH-1:0]           sr_data,
  output logic                       busy,
  output logic [1:0]                 done,
  output logic                       done_aborted
);

  state_e           r_state, w_state_nxt;
  op_e              r_op, w_sel_op;
  logic [7:0]       r_payload, w_sel_payload;
  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_nxt, w_cnt_inc, w_sel_len;
  logic             r_owner, r_ptr, r_out_en, w_sel, w_accept, w_abt_nxt;
  logic [1:0]       w_grant, w_ready, w_done_nxt;
  sr_cmd_t          w_cmd_nxt;

  rr_arbiter_2 u_arb (
    .i_req   (req.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // r_out_en keeps ready low while reset is applied, since ready is combinational.
  assign w_ready       = (r_state == ST_IDLE && r_out_en) ? w_grant : 2'b00;
  assign req.req_ready = w_ready;
  assign w_accept      = |(req.req_valid & w_ready);
  assign w_sel         = w_grant[1];
  assign w_sel_op      = op_e'(w_sel ? req.req_op[3:2] : req.req_op[1:0]);
  assign w_sel_payload = w_sel ? req.req_payload[15:8] : req.req_payload[7:0];
  assign w_sel_len     = eff_len(w_sel_op, w_sel ? req.req_len[7:4] : req.req_len[3:0]);
  assign w_cnt_inc     = r_cnt + 4'd1;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the command/done values registered at the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = '0;
    w_done_nxt  = 2'b00;
    w_abt_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
          w_cmd_nxt   = sr_cmd(w_sel_op, w_sel_payload, 3'd0);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort || r_cnt == (r_len - 4'd1)) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = r_owner ? 2'b10 : 2'b01;
          w_abt_nxt   = abort;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_cmd_nxt = sr_cmd(r_op, r_payload, w_cnt_inc[2:0]);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, arbitration pointer and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_en     <= 1'b0;
      r_op         <= OP_CLEAR;
      r_payload    <= 8'h00;
      r_len        <= 4'd0;
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_ptr        <= 1'b0;
      sr_reset     <= 1'b0;
      sr_ctrl      <= 2'd0;
      sr_data      <= '0;
      busy         <= 1'b0;
      done         <= 2'b00;
      done_aborted <= 1'b0;
    end else begin
      r_out_en     <= 1'b1;
      r_cnt        <= w_cnt_nxt;
      sr_reset     <= w_cmd_nxt.rst;
      sr_ctrl      <= w_cmd_nxt.ctrl;
      sr_data      <= w_cmd_nxt.data;
      busy         <= (w_state_nxt != ST_IDLE);
      done         <= w_done_nxt;
      done_aborted <= w_abt_nxt;
      if (w_accept) begin
        r_op      <= w_sel_op;
        r_payload <= w_sel_payload;
        r_len     <= w_sel_len;
        r_owner   <= w_sel;
        r_ptr     <= ~w_sel;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_scheduler.sv
module tb_shift_register_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       abort = 1'b0;
  logic       sr_reset;
  logic [1:0] sr_ctrl;
  logic [7:0] sr_data;
  logic       busy;
  logic [1:0] done;
  logic       done_aborted;
  logic [7:0] q;
  int         n_tests = 0;
  int         n_fail = 0;

  shift_register_scheduler_if u_if ();

  shift_register_scheduler #(.WIDTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (u_if),
    .abort        (abort),
    .sr_reset     (sr_reset),
    .sr_ctrl      (sr_ctrl),
    .sr_data      (sr_data),
    .busy         (busy),
    .done         (done),
    .done_aborted (done_aborted)
  );

  always #5 clk = ~clk;

  // Attached shift register driven by the scheduler commands.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) q <= 8'h00;
    else if (sr_reset) q <= 8'h00;
    else begin
      case (sr_ctrl)
        2'd1: q <= {sr_data[7], q[7:1]};
        2'd2: q <= {q[6:0], sr_data[0]};
        2'd3: q <= sr_data;
        default: q <= q;
      endcase
    end
  end

  task automatic drive(input logic [1:0] v, input logic [3:0] op,
                       input logic [15:0] pl, input logic [7:0] len);
    u_if.req_valid   = v;
    u_if.req_op      = op;
    u_if.req_payload = pl;
    u_if.req_len     = len;
  endtask

  task automatic test_reset();
    drive(2'b11, 4'hF, 16'hFFFF, 8'h00);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (u_if.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", u_if.req_ready); end
    n_tests++;
    if ({sr_reset, sr_ctrl, sr_data, busy, done, done_aborted} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got rst=%b ctrl=%0d data=%h busy=%b done=%b ab=%b want all 0",
                         sr_reset, sr_ctrl, sr_data, busy, done, done_aborted);
    end
    drive(2'b00, 4'h0, 16'h0000, 8'h00);
    resetn = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (u_if.req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_no_valid_ready: got %b want 00", u_if.req_ready); end
  endtask

  task automatic test_arbitration();
    logic [7:0] pl;
    logic [7:0] exp_d;
    pl = 8'h0F;
    @(negedge clk);
    drive(2'b11, {2'd2, 2'd3}, {8'h0F, 8'hF0}, {4'd8, 4'd0});
    #1;
    n_tests++;
    if (u_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL arb_first_A: got %b want 01", u_if.req_ready); end
    @(negedge clk);
    u_if.req_valid = 2'b10;
    #1;
    n_tests++;
    if ({sr_ctrl, sr_data, u_if.req_ready, busy} !== {2'd3, 8'hF0, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL arb_load_cmd: got ctrl=%0d data=%h rdy=%b busy=%b want 3 f0 00 1", sr_ctrl, sr_data, u_if.req_ready, busy);
    end
    @(negedge clk); #1;
    n_tests++;
    if (done !== 2'b01 || q !== 8'hF0) begin n_fail++; $display("FAIL arb_A_done: got done=%b q=%h want 01 f0", done, q); end
    @(negedge clk); #1;
    n_tests++;
    if (u_if.req_ready !== 2'b10 || busy !== 1'b0) begin n_fail++; $display("FAIL arb_then_B: got rdy=%b busy=%b want 10 0", u_if.req_ready, busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      u_if.req_valid = 2'b00;
      #1;
      exp_d = 8'h00;
      exp_d[0] = pl[7-i];
      n_tests++;
      if (sr_ctrl !== 2'd2 || sr_data !== exp_d) begin
        n_fail++; $display("FAIL arb_B_left_%0d: got ctrl=%0d data=%h want 2 %h", i, sr_ctrl, sr_data, exp_d);
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (done !== 2'b10 || q !== 8'h0F) begin n_fail++; $display("FAIL arb_B_done: got done=%b q=%h want 10 0f", done, q); end
  endtask

  task automatic test_right_a5();
    logic [7:0] pl;
    logic [7:0] exp_d;
    pl = 8'hA5;
    @(negedge clk);
    drive(2'b01, {2'd0, 2'd1}, {8'h00, 8'hA5}, {4'd0, 4'd8});
    #1;
    n_tests++;
    if (u_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL a5_ready: got %b want 01", u_if.req_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      u_if.req_valid = 2'b00;
      #1;
      exp_d = 8'h00;
      exp_d[7] = pl[i];
      n_tests++;
      if (sr_ctrl !== 2'd1 || sr_data !== exp_d || busy !== 1'b1) begin
        n_fail++; $display("FAIL a5_right_%0d: got ctrl=%0d data=%h busy=%b want 1 %h 1", i, sr_ctrl, sr_data, busy, exp_d);
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (done !== 2'b01 || done_aborted !== 1'b0 || sr_ctrl !== 2'd0 || sr_data !== 8'h00 || q !== 8'hA5) begin
      n_fail++; $display("FAIL a5_done: got done=%b ab=%b ctrl=%0d data=%h q=%h want 01 0 0 00 a5", done, done_aborted, sr_ctrl, sr_data, q);
    end
    @(negedge clk); #1;
    n_tests++;
    if (done !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL a5_single_pulse: got done=%b busy=%b want 00 0", done, busy); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    drive(2'b01, 4'h0, 16'h00FF, 8'h00);
    #1;
    n_tests++;
    if (u_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL clr_ready: got %b want 01", u_if.req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      u_if.req_valid = 2'b00;
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (c == 0) begin
        n_tests++;
        if ({sr_reset, sr_ctrl, sr_data} !== {1'b1, 2'd0, 8'h00}) begin
          n_fail++; $display("FAIL clr_cmd: got rst=%b ctrl=%0d data=%h want 1 0 00", sr_reset, sr_ctrl, sr_data);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (q !== 8'h00 || done !== 2'b01 || sr_reset !== 1'b0) begin
          n_fail++; $display("FAIL clr_done: got q=%h done=%b rst=%b want 00 01 0", q, done, sr_reset);
        end
      end
    end
    n_tests++;
    if (busy_cnt != 2) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want 2", busy_cnt); end
  endtask

  task automatic test_short_len();
    int done_cyc;
    logic [1:0] done_val;
    done_cyc = -1;
    done_val = 2'b00;
    @(negedge clk);
    drive(2'b10, {2'd1, 2'd0}, {8'h05, 8'h00}, {4'd3, 4'd0});
    #1;
    n_tests++;
    if (u_if.req_ready !== 2'b10) begin n_fail++; $display("FAIL len3_ready: got %b want 10", u_if.req_ready); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      u_if.req_valid = 2'b00;
      #1;
      if (c == 2) begin n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL len3_q1: got %h want 80", q); end end
      if (c == 3) begin n_tests++; if (q !== 8'h40) begin n_fail++; $display("FAIL len3_q2: got %h want 40", q); end end
      if (c == 4) begin n_tests++; if (q !== 8'hA0) begin n_fail++; $display("FAIL len3_q3: got %h want a0", q); end end
      if (done !== 2'b00 && done_cyc < 0) begin done_cyc = c; done_val = done; end
    end
    n_tests++;
    if (done_cyc != 4 || done_val !== 2'b10) begin
      n_fail++; $display("FAIL len3_done_timing: got cycle %0d done=%b want cycle 4 done=10", done_cyc, done_val);
    end
  endtask

  task automatic test_len_boundary();
    logic [3:0] lens [5];
    int         exp_n [5];
    int         cnt;
    logic       seen;
    lens  = '{4'd0, 4'd9, 4'd15, 4'd1, 4'd8};
    exp_n = '{8, 8, 8, 1, 8};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(2'b01, {2'd0, 2'd2}, {8'h00, 8'h81}, {4'd0, lens[k]});
      cnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        u_if.req_valid = 2'b00;
        #1;
        if (sr_ctrl === 2'd2) cnt++;
        if (done === 2'b01) seen = 1'b1;
      end
      n_tests++;
      if (cnt != exp_n[k] || !seen) begin
        n_fail++; $display("FAIL len_%0d_cycles: got %0d shifts done_seen=%b want %0d shifts", lens[k], cnt, seen, exp_n[k]);
      end
    end
  endtask

  task automatic test_abort();
    int extra;
    extra = 0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 2'b00 || done_aborted !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_ignored: got busy=%b done=%b ab=%b want 0 00 0", busy, done, done_aborted);
    end
    drive(2'b01, {2'd0, 2'd1}, {8'h00, 8'hFF}, {4'd0, 4'd8});
    @(negedge clk);
    u_if.req_valid = 2'b00;
    #1;
    n_tests++;
    if (sr_ctrl !== 2'd1) begin n_fail++; $display("FAIL abort_run0: got ctrl=%0d want 1", sr_ctrl); end
    @(negedge clk);
    abort = 1'b1;
    #1;
    n_tests++;
    if (sr_ctrl !== 2'd1) begin n_fail++; $display("FAIL abort_run1: got ctrl=%0d want 1", sr_ctrl); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_tests++;
    if (sr_ctrl !== 2'd0 || sr_data !== 8'h00 || done !== 2'b01 || done_aborted !== 1'b1) begin
      n_fail++; $display("FAIL abort_done: got ctrl=%0d data=%h done=%b ab=%b want 0 00 01 1", sr_ctrl, sr_data, done, done_aborted);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (done !== 2'b00 || done_aborted !== 1'b0 || sr_ctrl !== 2'd0) extra++;
    end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL abort_single_pulse: got %0d extra active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int   done_seen;
    logic got;
    done_seen = 0;
    got = 1'b0;
    @(negedge clk);
    drive(2'b01, {2'd0, 2'd1}, {8'h00, 8'hFF}, {4'd0, 4'd8});
    @(negedge clk);
    u_if.req_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({sr_reset, sr_ctrl, sr_data, busy, done, done_aborted, u_if.req_ready} !== 17'd0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got ctrl=%0d data=%h busy=%b done=%b rdy=%b want all 0",
                         sr_ctrl, sr_data, busy, done, u_if.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (done !== 2'b00) done_seen++;
    end
    resetn = 1'b1;
    drive(2'b11, {2'd3, 2'd3}, {8'hC3, 8'h3C}, 8'h00);
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk); #1;
      if (done !== 2'b00) done_seen++;
      if (u_if.req_ready !== 2'b00) got = 1'b1;
    end
    n_tests++;
    if (done_seen != 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d done cycles want 0", done_seen); end
    n_tests++;
    if (u_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL midrun_A_after_reset: got %b want 01", u_if.req_ready); end
    @(negedge clk);
    u_if.req_valid = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy [10];
    exp_rdy = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    @(negedge clk);
    drive(2'b11, {2'd3, 2'd3}, {8'h22, 8'h11}, 8'h00);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if (u_if.req_ready !== exp_rdy[c]) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %b want %b", c, u_if.req_ready, exp_rdy[c]);
      end
      if (c == 2) begin n_tests++; if (q !== 8'h22) begin n_fail++; $display("FAIL b2b_q_B: got %h want 22", q); end end
      if (c == 5) begin n_tests++; if (q !== 8'h11) begin n_fail++; $display("FAIL b2b_q_A: got %h want 11", q); end end
      @(negedge clk);
    end
    u_if.req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    drive(2'b00, 4'h0, 16'h0000, 8'h00);
    test_reset();
    test_arbitration();
    test_right_a5();
    test_clear();
    test_short_len();
    test_len_boundary();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
